// File: rtl/mux_shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier.
//   DEFAULT_WIDTH : default operand width
//   state_t       : controller state encoding (2'd3 is illegal and recovers to IDLE)
package mux_shift_add_multiplier_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux_shift_add_multiplier_ripple_adder.sv
// Ripple-carry adder built from single-bit full_adder cells.
//   full_adder   : a, b, cin -> sum, cout (1 bit)
//   ripple_adder : a[WIDTH], b[WIDTH], cin -> sum[WIDTH], cout
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign sum  = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

module ripple_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;
  assign cout       = w_carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_carry[i]),
      .sum  (sum[i]),
      .cout (w_carry[i+1])
    );
  end

endmodule

// File: rtl/mux_shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one partial product per cycle.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake, a (multiplicand), b (multiplier)
//   out_valid/out_ready   : product handshake, product = a*b (2*WIDTH bits)
//   busy                  : high while an operation is in RUN or DONE
module mux_shift_add_multiplier
  import mux_shift_add_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic               r_armed;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_pp;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  // r_armed keeps in_ready low while reset is held and for the edge it is
  // released on; it rises at the first clock edge after reset deasserts.
  assign in_ready  = r_armed && (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign product   = r_acc;

  assign w_accept  = in_ready && in_valid;
  assign w_last    = (r_count == CW'(WIDTH - 1));

  // Partial-product mux: multiplicand or zero, by the current multiplier LSB.
  assign w_pp = r_mplier[0] ? r_mcand : '0;

  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (r_acc[2*WIDTH-1:WIDTH]),
    .b    (w_pp),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_next;
      r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        ST_RUN: begin
          // Sum lands in the upper half with its carry; the lower half shifts
          // right, pushing out the product bit already finalised.
          r_acc    <= {w_cout, w_sum, r_acc[WIDTH-1:1]};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          if (!w_last) r_count <= r_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_shift_add_multiplier.sv
module tb_mux_shift_add_multiplier;
  import mux_shift_add_multiplier_pkg::*;

  localparam int unsigned W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*W-1:0]   product;
  logic             busy;

  mux_shift_add_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned    n_checks = 0;
  int unsigned    n_err    = 0;
  int unsigned    cyc      = 0;
  bit             rand_stall = 1'b0;
  logic [2*W-1:0] exp_q[$];
  int unsigned    acc_cyc_q[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound expired, got timeout, expected completion (t=%0t)", name, $time);
  endtask

  // Monitor/scoreboard: everything sampled on the falling edge, half a cycle
  // away from the DUT's active edge and from the driver's updates.
  bit prev_ov = 1'b0;
  bit popped  = 1'b0;
  always @(negedge clk) begin
    logic [2*W-1:0] model;
    if (!rst_n) begin
      prev_ov = 1'b0;
      popped  = 1'b0;
    end else begin
      check("ready_valid_exclusive", 32'(in_ready & out_valid), 32'd0);
      check("busy_vs_state", 32'(busy), 32'(dut.r_state != ST_IDLE));
      if (popped) check("in_ready_after_handshake", 32'(in_ready), 32'd1);
      popped = 1'b0;
      if (in_valid && in_ready) begin
        model = (2*W)'(a) * (2*W)'(b);
        exp_q.push_back(model);
        acc_cyc_q.push_back(cyc + 1);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_out_valid: got out_valid=1 product=0x%0h, expected no result pending", product);
        end else begin
          if (!prev_ov) check("latency", 32'(cyc - acc_cyc_q[0]), 32'(W));
          check("product", 32'(product), 32'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_cyc_q.pop_front());
            popped = 1'b1;
          end
        end
      end
      prev_ov = out_valid && !out_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_ready();
    int unsigned n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) fail_bound("wait_in_ready");
  endtask

  // Presents one operand pair for exactly its accept edge. With junk set it
  // then wiggles in_valid/a/b while the operation runs, until DONE.
  task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit junk);
    int unsigned n = 0;
    wait_ready();
    a = ia;
    b = ib;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (junk) begin
      while (!out_valid && n < 50) begin
        in_valid = 1'($urandom_range(0, 1));
        a = 8'hFF;
        b = 8'($urandom);
        tick();
        n++;
      end
      in_valid = 1'b0;
      if (!out_valid) fail_bound("junk_wait_done");
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || out_valid) fail_bound("drain");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", 32'(in_ready), 32'd0);
    tick();
    check("in_ready_first_edge", 32'(in_ready), 32'd1);

    // Basic product
    out_ready = 1'b1;
    send(8'h0D, 8'h0B, 1'b0);
    drain();
    check("held_0x0D_0x0B", 32'(product), 32'h008F);

    // Maximum operands and carry into the top bit
    send(8'hFF, 8'hFF, 1'b0);
    drain();
    check("held_0xFF_0xFF", 32'(product), 32'hFE01);
    send(8'h80, 8'h02, 1'b0);
    drain();
    check("held_0x80_0x02", 32'(product), 32'h0100);

    // Zero operands
    send(8'h00, 8'hA5, 1'b0);
    drain();
    check("held_0x00_0xA5", 32'(product), 32'h0000);
    send(8'hA5, 8'h00, 1'b0);
    drain();
    check("held_0xA5_0x00", 32'(product), 32'h0000);

    // Backpressure with ignored in_valid during RUN
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b1);
    repeat (5) tick();
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_product", 32'(product), 32'h03A8);
    out_ready = 1'b1;
    drain();

    // Reset after the 4th RUN edge
    send(8'h77, 8'h99, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    acc_cyc_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(8'h03, 8'h05, 1'b0);
    drain();
    check("held_0x03_0x05", 32'(product), 32'h000F);

    // Random operands with random downstream stalls
    rand_stall = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(8'($urandom), 8'($urandom), 1'b0);
    end
    rand_stall = 1'b0;
    out_ready  = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
